data_sync: RTL and testbench
============================

DATA_SYNC -- requirements
Module: data_sync

Interface
REQ-001 SHALL provide parameter BUS_WIDTH, default 8, width of captured data bus (legal >= 1).
REQ-002 SHALL provide parameter NUM_STAGES, default 2, number of synchronizer flops on the enable path (legal >= 2).
REQ-003 SHALL have port CLK  input  1  single destination-domain clock; all flops rising-edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port UNSYNC_BUS  input  BUS_WIDTH  source-domain data, stable while BUS_EN high.
REQ-006 SHALL have port BUS_EN  input  1  source-domain asynchronous level request; the only multi-flop-synchronized input.
REQ-007 SHALL have port SYNC_BUS  output  BUS_WIDTH  registered captured data.
REQ-008 SHALL have port ENABLE_PULSE  output  1  registered one-cycle strobe marking new SYNC_BUS value.
REQ-009 SHALL have port ACK  output  1  registered handshake acknowledge; present only under DATA_SYNC_ACK_EN.

Function
REQ-010 SHALL pass BUS_EN through a NUM_STAGES-flop chain; last flop is en_sync, plus one further flop en_sync_d.
REQ-011 SHALL define rise = en_sync & ~en_sync_d and fall = ~en_sync & en_sync_d.
REQ-012 SHALL, at an edge where rise=1 and state=IDLE, load SYNC_BUS <= UNSYNC_BUS and set ENABLE_PULSE=1 for exactly one cycle.
REQ-013 SHALL hold SYNC_BUS unchanged at all other edges; ENABLE_PULSE SHALL be 0 at all other edges.
REQ-014 Latency: BUS_EN rising before edge 1 SHALL yield SYNC_BUS/ENABLE_PULSE valid after edge NUM_STAGES+1.
REQ-015 SHALL never sample UNSYNC_BUS except on the capture edge of REQ-012.
REQ-016 A BUS_EN high shorter than one CLK period MAY be missed; no capture on a missed request is required.
REQ-017 A BUS_EN low gap shorter than one CLK period MAY be missed; en_sync SHALL then stay high and no second capture SHALL occur.

Reset
REQ-018 RST high SHALL immediately clear synchronizer chain, en_sync_d, SYNC_BUS (all 0), ENABLE_PULSE=0, ACK=0, state=IDLE.
REQ-019 Reset mid-transfer SHALL abandon the transfer; if BUS_EN is still high after RST release, a fresh capture SHALL occur NUM_STAGES+1 edges after release.
REQ-020 No output SHALL change on the RST deassertion edge itself.

Configuration
REQ-021 Macro DATA_SYNC_ACK_EN SHALL select four-phase handshake mode.
REQ-022 With DATA_SYNC_ACK_EN: FSM states IDLE, WAIT_LOW; IDLE->WAIT_LOW on capture edge, ACK set 1 on that same edge.
REQ-023 With DATA_SYNC_ACK_EN: in WAIT_LOW ACK SHALL stay 1 and rise SHALL be ignored; on first edge with en_sync=0 ACK<=0, state<=IDLE.
REQ-024 With DATA_SYNC_ACK_EN: rise coincident with the WAIT_LOW->IDLE edge is impossible (en_sync=0); next capture requires a fresh rise from IDLE.
REQ-025 Without DATA_SYNC_ACK_EN: ACK port and WAIT_LOW state SHALL not exist; every rise SHALL capture (state permanently IDLE).

Verification (BUS_WIDTH=8, NUM_STAGES=2, 10 ns CLK)
REQ-026 Reset: RST=1 with BUS_EN=1, UNSYNC_BUS=8'hA5 -> SYNC_BUS=8'h00, ENABLE_PULSE=0, ACK=0 throughout reset.
REQ-027 Basic capture: UNSYNC_BUS=8'h3C, BUS_EN 0->1 before edge 1 -> SYNC_BUS unchanged after edges 1-2, SYNC_BUS=8'h3C and ENABLE_PULSE=1 after edge 3, ENABLE_PULSE=0 after edge 4.
REQ-028 Data isolation: after REQ-027 capture change UNSYNC_BUS to 8'hFF with BUS_EN held 1 -> SYNC_BUS stays 8'h3C, no further pulse.
REQ-029 Handshake (macro on): BUS_EN held 1 for 10 cycles then 0 -> ACK 1 from capture edge until 3 edges after BUS_EN falls, then 0; only one ENABLE_PULSE.
REQ-030 Back-to-back (macro off): BUS_EN high 4 cycles, low 3 cycles, high again with 8'h11 then 8'h22 -> two ENABLE_PULSEs, SYNC_BUS 8'h11 then 8'h22.
REQ-031 Reset mid-transfer: assert RST one cycle after capture, release with BUS_EN=1, UNSYNC_BUS=8'h5A -> outputs clear, new capture of 8'h5A after 3rd edge post-release.

Source files
------------

// File: rtl/data_sync_if.sv
// Purpose : bundles the source-side request/data and destination-side capture
//           signals of data_sync into one port.
// Ports   : UNSYNC_BUS/BUS_EN (source -> sync), SYNC_BUS/ENABLE_PULSE and
//           ACK (sync -> consumer, ACK only when DATA_SYNC_ACK_EN is defined).
// Modports: master = source/consumer side, slave = data_sync itself.
interface data_sync_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] UNSYNC_BUS;
  logic                 BUS_EN;
  logic [BUS_WIDTH-1:0] SYNC_BUS;
  logic                 ENABLE_PULSE;
`ifdef DATA_SYNC_ACK_EN
  logic                 ACK;

  modport master (output UNSYNC_BUS, output BUS_EN,
                  input  SYNC_BUS, input ENABLE_PULSE, input ACK);
  modport slave  (input  UNSYNC_BUS, input BUS_EN,
                  output SYNC_BUS, output ENABLE_PULSE, output ACK);
`else
  modport master (output UNSYNC_BUS, output BUS_EN,
                  input  SYNC_BUS, input ENABLE_PULSE);
  modport slave  (input  UNSYNC_BUS, input BUS_EN,
                  output SYNC_BUS, output ENABLE_PULSE);
`endif
endinterface

// File: rtl/data_sync.sv
// Purpose : multi-flop synchronizes a level request BUS_EN and captures the
//           quasi-static UNSYNC_BUS once per request into SYNC_BUS.
// Latency : request rising before edge 1 -> SYNC_BUS/ENABLE_PULSE valid after
//           edge NUM_STAGES+1; ENABLE_PULSE lasts exactly one cycle.
// Backpressure: none in the default build; with DATA_SYNC_ACK_EN defined a
//           four-phase handshake holds ACK high until the request drops, and
//           further requests are ignored until then.
// Ports   : CLK, RST (async active-high), bus (data_sync_if.slave).
// Macro   : DATA_SYNC_ACK_EN enables the ACK output and WAIT_LOW state.
module data_sync #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input logic        CLK,
  input logic        RST,
  data_sync_if.slave bus
);

  // Synchronizer chain; only BUS_EN crosses domains. UNSYNC_BUS is sampled
  // solely on the capture edge, by which time it has been stable for
  // NUM_STAGES cycles.
  logic [NUM_STAGES-1:0] sync_chain;
  logic                  en_sync;
  logic                  en_sync_d;
  logic                  rise;
  logic                  capture;

  logic [BUS_WIDTH-1:0]  sync_bus_q;
  logic                  enable_pulse_q;

  assign en_sync = sync_chain[NUM_STAGES-1];
  assign rise    = en_sync & ~en_sync_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_chain <= '0;
      en_sync_d  <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[NUM_STAGES-2:0], bus.BUS_EN};
      en_sync_d  <= en_sync;
    end
  end

`ifdef DATA_SYNC_ACK_EN
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_LOW = 1'b1;

  logic [0:0] state;
  logic       ack_q;
  logic       fall;

  // In WAIT_LOW en_sync_d is always 1 (we only stay there while en_sync is
  // high), so the first en_sync=0 edge there is exactly a fall.
  assign fall    = ~en_sync & en_sync_d;
  assign capture = rise & (state == IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ack_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state <= WAIT_LOW;
            ack_q <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (fall) begin
            state <= IDLE;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ACK = ack_q;
`else
  // Without the handshake every synchronized rising edge is a new request.
  assign capture = rise;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_bus_q     <= '0;
      enable_pulse_q <= 1'b0;
    end else begin
      enable_pulse_q <= capture;
      if (capture) begin
        sync_bus_q <= bus.UNSYNC_BUS;
      end
    end
  end

  assign bus.SYNC_BUS     = sync_bus_q;
  assign bus.ENABLE_PULSE = enable_pulse_q;

endmodule

// File: tb/tb_data_sync.sv
// Directed bench for data_sync (BUS_WIDTH=8, NUM_STAGES=2, 10 ns clock).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// ACK checks are compiled in only when DATA_SYNC_ACK_EN is defined.
module tb_data_sync;
  logic CLK_tb;
  logic rst_tb;
  int   total;
  int   bad;

  data_sync_if #(.BUS_WIDTH(8)) bus_if ();

  data_sync #(
    .BUS_WIDTH (8),
    .NUM_STAGES(2)
  ) dut (
    .CLK(CLK_tb),
    .RST(rst_tb),
    .bus(bus_if)
  );

  initial CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  task automatic step();
    @(posedge CLK_tb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp_bus, input logic exp_pulse);
    chk({tag, ".sync_bus"}, 32'(bus_if.SYNC_BUS), 32'(exp_bus));
    chk({tag, ".pulse"}, 32'(bus_if.ENABLE_PULSE), 32'(exp_pulse));
  endtask

  task automatic chk_ack(input string tag, input logic exp_ack);
`ifdef DATA_SYNC_ACK_EN
    chk({tag, ".ack"}, 32'(bus_if.ACK), 32'(exp_ack));
`else
    if (exp_ack === 1'bx) $display("unused ack expectation in %s", tag);
`endif
  endtask

  initial begin
    logic [7:0] exp_bus;
    logic       exp_pulse;
    logic       exp_ack;
    total = 0;
    bad   = 0;

    // Reset with the request already high: everything stays cleared.
    rst_tb            = 1'b1;
    bus_if.BUS_EN     = 1'b1;
    bus_if.UNSYNC_BUS = 8'hA5;
    #1;
    chk_out("rst_immediate", 8'h00, 1'b0);
    chk_ack("rst_immediate", 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("rst_hold", 8'h00, 1'b0);
      chk_ack("rst_hold", 1'b0);
    end
    bus_if.BUS_EN = 1'b0;
    rst_tb        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("post_release_idle", 8'h00, 1'b0);
    end

    // Basic capture: three-edge latency, one-cycle strobe.
    bus_if.UNSYNC_BUS = 8'h3C;
    bus_if.BUS_EN     = 1'b1;
    step();                               // edge 1
    chk_out("cap_e1", 8'h00, 1'b0);
    step();                               // edge 2
    chk_out("cap_e2", 8'h00, 1'b0);
    step();                               // edge 3
    chk_out("cap_e3", 8'h3C, 1'b1);
    chk_ack("cap_e3", 1'b1);
    step();                               // edge 4
    chk_out("cap_e4", 8'h3C, 1'b0);

    // Data isolation: source data changes while the request stays high.
    bus_if.UNSYNC_BUS = 8'hFF;
    for (int i = 5; i <= 10; i++) begin
      step();                             // edges 5..10
      chk_out("isolate", 8'h3C, 1'b0);
      chk_ack("isolate_ack", 1'b1);
    end

    // Request drops before edge 11: ACK clears on edge 13.
    bus_if.BUS_EN = 1'b0;
    step();                               // edge 11
    chk_ack("hs_e11", 1'b1);
    chk_out("hs_e11", 8'h3C, 1'b0);
    step();                               // edge 12
    chk_ack("hs_e12", 1'b1);
    step();                               // edge 13
    chk_ack("hs_e13", 1'b0);
    chk_out("hs_e13", 8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) step();

    // Back-to-back: high 4 cycles with 11, low 3 cycles, high with 22.
    for (int i = 1; i <= 14; i++) begin
      if (i == 1) begin
        bus_if.UNSYNC_BUS = 8'h11;
        bus_if.BUS_EN     = 1'b1;
      end else if (i == 5) begin
        bus_if.BUS_EN = 1'b0;
      end else if (i == 8) begin
        bus_if.UNSYNC_BUS = 8'h22;
        bus_if.BUS_EN     = 1'b1;
      end
      step();
      exp_pulse = (i == 3) || (i == 10);
      exp_bus   = (i < 3) ? 8'h3C : (i < 10) ? 8'h11 : 8'h22;
      exp_ack   = (i >= 3 && i <= 6) || (i >= 10);
      chk_out($sformatf("b2b_e%0d", i), exp_bus, exp_pulse);
      chk_ack($sformatf("b2b_e%0d", i), exp_ack);
    end

    // Reset mid-transfer, request still high at release.
    bus_if.BUS_EN = 1'b0;
    for (int i = 0; i < 5; i++) step();
    bus_if.UNSYNC_BUS = 8'h77;
    bus_if.BUS_EN     = 1'b1;
    step();
    step();
    step();
    chk_out("mid_cap", 8'h77, 1'b1);
    step();
    rst_tb = 1'b1;
    #1;
    chk_out("mid_rst_immediate", 8'h00, 1'b0);
    chk_ack("mid_rst_immediate", 1'b0);
    bus_if.UNSYNC_BUS = 8'h5A;
    step();
    step();
    chk_out("mid_rst_hold", 8'h00, 1'b0);
    rst_tb = 1'b0;
    #1;
    chk_out("mid_release", 8'h00, 1'b0);
    step();                               // first edge after release
    chk_out("mid_r1", 8'h00, 1'b0);
    chk_ack("mid_r1", 1'b0);
    step();
    chk_out("mid_r2", 8'h00, 1'b0);
    step();
    chk_out("mid_r3", 8'h5A, 1'b1);
    chk_ack("mid_r3", 1'b1);
    step();
    chk_out("mid_r4", 8'h5A, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
